// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit with next-PC prediction and instruction queue; optional BHT_EN branch history table
module inst_fetch #(
  parameter int          IQ_DEPTH = 8,
  parameter int          BHT_SIZE = 256,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_inst,
  output logic        iq_out_valid,
  output logic [31:0] iq_out_inst,
  output logic [31:0] iq_out_pc,
  output logic        iq_out_pred_taken,
  input  logic        issue_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_update,
  input  logic [31:0] br_update_pc,
  input  logic        br_update_taken
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(IQ_DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

  state_t        state, state_d;
  logic [31:0]   pc, pc_d, addr_d;
  logic          req_d;
  logic          push, pop;
  logic [PW:0]   count, post_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic [31:0]         q_inst [IQ_DEPTH];
  logic [31:0]         q_pc   [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] q_pred;

  logic        is_jal, is_br, br_taken, pred;
  logic [31:0] jal_imm, br_imm, next_pc;

  assign is_jal  = (mem_inst[6:0] == 7'h6f);
  assign is_br   = (mem_inst[6:0] == 7'h63);
  assign jal_imm = {{11{mem_inst[31]}}, mem_inst[31], mem_inst[19:12], mem_inst[20], mem_inst[30:21], 1'b0};
  assign br_imm  = {{19{mem_inst[31]}}, mem_inst[31], mem_inst[7], mem_inst[30:25], mem_inst[11:8], 1'b0};
  assign pred    = is_jal | (is_br & br_taken);
  assign next_pc = is_jal             ? pc + jal_imm :
                   (is_br & br_taken) ? pc + br_imm  :
                                        pc + 32'd4;

`ifdef BHT_EN
  localparam int BW = $clog2(BHT_SIZE);

  logic [1:0]    bht [BHT_SIZE];
  logic [BW-1:0] rd_idx, up_idx;
  logic          unused_ok;

  assign rd_idx   = pc[BW+1:2];
  assign up_idx   = br_update_pc[BW+1:2];
  assign br_taken = bht[rd_idx][1];
  assign unused_ok = &{1'b0, br_update_pc[31:BW+2], br_update_pc[1:0]};

  // Train 2-bit saturating counters; a same-cycle lookup reads the pre-update value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
    end else if (br_update) begin
      if (br_update_taken && bht[up_idx] != 2'b11)
        bht[up_idx] <= bht[up_idx] + 2'd1;
      else if (!br_update_taken && bht[up_idx] != 2'b00)
        bht[up_idx] <= bht[up_idx] - 2'd1;
    end
  end
`else
  logic unused_ok;

  assign br_taken  = 1'b0;
  assign unused_ok = &{1'b0, br_update, br_update_pc, br_update_taken, BHT_SIZE[0]};
`endif

  assign pop          = iq_out_valid & issue_ready;
  assign post_cnt     = count + (PW+1)'(1) - (PW+1)'(pop);
  assign iq_out_valid = (count != '0);
  assign iq_out_inst  = q_inst[rd_ptr];
  assign iq_out_pc    = q_pc[rd_ptr];
  assign iq_out_pred_taken = q_pred[rd_ptr];

  // State, request and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      mem_req  <= req_d;
      mem_addr <= addr_d;
    end
  end

  // Next-state logic: flush first, then request issue / ack handling
  always_comb begin
    state_d = state;
    pc_d    = pc;
    req_d   = mem_req;
    addr_d  = mem_addr;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          pc_d = flush_pc;
        end else if (count < FULL_CNT) begin
          req_d   = 1'b1;
          addr_d  = pc;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          pc_d = flush_pc;
          if (mem_ack) addr_d = flush_pc;
          else         state_d = DISCARD;
        end else if (mem_ack) begin
          push = 1'b1;
          pc_d = next_pc;
          if (post_cnt < FULL_CNT) begin
            addr_d = next_pc;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (flush) begin
          pc_d = flush_pc;
          if (mem_ack) begin
            addr_d  = flush_pc;
            state_d = BUSY;
          end
        end else if (mem_ack) begin
          addr_d  = pc;
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Queue pointers and occupancy; flush empties the queue whatever else happens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Queue storage written at the ack edge; head outputs read registered entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
      q_pred <= '0;
    end else if (push) begin
      q_inst[wr_ptr] <= mem_inst;
      q_pc[wr_ptr]   <= pc;
      q_pred[wr_ptr] <= pred;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

  localparam int DEPTH   = 8;
  localparam int BHT_N   = 256;
  localparam int K_PLAIN = 0;
  localparam int K_JAL   = 1;
  localparam int K_BR    = 2;
  localparam int K_JALR  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_inst = 32'h0;
  logic        iq_out_valid;
  logic [31:0] iq_out_inst;
  logic [31:0] iq_out_pc;
  logic        iq_out_pred_taken;
  logic        issue_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        br_update = 1'b0;
  logic [31:0] br_update_pc = 32'h0;
  logic        br_update_taken = 1'b0;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_inst(mem_inst),
    .iq_out_valid(iq_out_valid), .iq_out_inst(iq_out_inst), .iq_out_pc(iq_out_pc),
    .iq_out_pred_taken(iq_out_pred_taken), .issue_ready(issue_ready),
    .flush(flush), .flush_pc(flush_pc),
    .br_update(br_update), .br_update_pc(br_update_pc), .br_update_taken(br_update_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] next;
    logic        pred;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          pops  = 0;
  ent_t        model_q[$];
  logic [31:0] m_pc = 32'h0;
  bit          stale = 1'b0;
  int          bht_m[BHT_N];
  vec_t        vecs[7];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name);
    for (int n = 0; n < 10 && !mem_req; n++) tick();
    check1(name, mem_req, 1'b1);
  endtask

  task automatic bht_train(input logic [31:0] p, input bit t);
    int i;
    i = int'((p >> 2) % 32'(BHT_N));
    if (t) bht_m[i] = (bht_m[i] == 3) ? 3 : bht_m[i] + 1;
    else   bht_m[i] = (bht_m[i] == 0) ? 0 : bht_m[i] - 1;
  endtask

  function automatic logic model_pred(input int kind, input logic [31:0] p);
`ifdef BHT_EN
    if (kind == K_BR) return bht_m[int'((p >> 2) % 32'(BHT_N))] >= 2;
`endif
    return kind == K_JAL;
  endfunction

  // Redirect to p, acking any outstanding request in the same cycle so nothing stale remains
  task automatic sync(input logic [31:0] p);
    flush = 1'b1; flush_pc = p; mem_ack = mem_req; mem_inst = 32'h0000006f;
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    model_q.delete();
    m_pc  = p;
    stale = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    sync(v.pc);
    check1("vec_flush_empty", iq_out_valid, 1'b0);
    wait_req("vec_req");
    check("vec_addr", mem_addr, v.pc);
    mem_ack = 1'b1; mem_inst = v.inst;
    tick();
    mem_ack = 1'b0;
    check1("vec_valid", iq_out_valid, 1'b1);
    check("vec_inst", iq_out_inst, v.inst);
    check("vec_pc", iq_out_pc, v.pc);
    check1("vec_pred", iq_out_pred_taken, v.pred);
    check1("vec_backtoback", mem_req, 1'b1);
    check("vec_next", mem_addr, v.next);
  endtask

  task automatic gen(input bit mixed, output logic [31:0] inst, output int kind, output logic [31:0] off);
    int r, o;
    r   = mixed ? int'($urandom_range(0, 9)) : 0;
    o   = int'($urandom_range(0, 1023)) - 512;
    off = 32'(o * 2);
    if (r < 4) begin
      kind = K_PLAIN;
      inst = {12'($urandom_range(0, 4095)), 5'd1, 3'b000, 5'd1, 7'h13};
    end else if (r < 6) begin
      kind = K_JAL;
      inst = {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'h6f};
    end else if (r < 9) begin
      kind = K_BR;
      inst = {off[12], off[10:5], 5'd2, 5'd1, 3'b000, off[4:1], off[11], 7'h63};
    end else begin
      kind = K_JALR;
      inst = {12'h0, 5'd1, 3'b000, 5'd1, 7'h67};
    end
  endtask

  // Memory responder plus decoder, checked against a queue model of the fetch stream
  task automatic traffic(input int cycles, input int ack_pct, input int rdy_pct,
                         input int flush_pct, input int upd_pct, input bit mixed);
    logic [31:0] inst, off, upc;
    int          kind;
    bit          do_ack, do_flush, do_pop, do_upd, ut;
    ent_t        e;
    for (int c = 0; c < cycles; c++) begin
      check1("q_valid", iq_out_valid, model_q.size() != 0);
      if (model_q.size() == DEPTH) check1("full_no_req", mem_req, 1'b0);
      if (model_q.size() != 0) begin
        check("head_inst", iq_out_inst, model_q[0].inst);
        check("head_pc", iq_out_pc, model_q[0].pc);
        check1("head_pred", iq_out_pred_taken, model_q[0].pred);
      end
      gen(mixed, inst, kind, off);
      do_flush = $urandom_range(0, 99) < flush_pct;
      do_ack   = mem_req && ($urandom_range(0, 99) < ack_pct);
      do_upd   = $urandom_range(0, 99) < upd_pct;
      ut       = $urandom_range(0, 1) == 1;
      upc      = 32'($urandom_range(0, 1023)) << 2;
      issue_ready = $urandom_range(0, 99) < rdy_pct;
      do_pop   = (model_q.size() != 0) && issue_ready;
      mem_ack  = do_ack;
      mem_inst = inst;
      flush    = do_flush;
      flush_pc = 32'($urandom_range(0, 4095)) << 2;
      br_update = do_upd; br_update_pc = upc; br_update_taken = ut;

      if (do_pop) begin
        void'(model_q.pop_front());
        pops++;
      end
      if (do_flush) begin
        model_q.delete();
        stale = mem_req && !do_ack;
        m_pc  = flush_pc;
      end else if (do_ack) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          check("ack_addr", mem_addr, m_pc);
          e.inst = inst;
          e.pc   = m_pc;
          e.pred = model_pred(kind, m_pc);
          model_q.push_back(e);
          m_pc = (kind == K_JAL || (kind == K_BR && e.pred)) ? m_pc + off : m_pc + 32'd4;
        end
      end
      if (do_upd) bht_train(upc, ut);
      tick();
    end
    mem_ack = 1'b0; flush = 1'b0; issue_ready = 1'b0; br_update = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h10,  32'h0080006f, 32'h18,       1'b1};
    vecs[1] = '{32'h10,  32'hff9ff06f, 32'h08,       1'b1};
    vecs[2] = '{32'h40,  32'hfe000ee3, 32'h44,       1'b0};
    vecs[3] = '{32'h200, 32'h00100093, 32'h204,      1'b0};
    vecs[4] = '{32'h300, 32'h000080e7, 32'h304,      1'b0};
    vecs[5] = '{32'h0,   32'hff9ff06f, 32'hfffffff8, 1'b1};
    vecs[6] = '{32'h80,  32'h00209463, 32'h84,       1'b0};
    for (int i = 0; i < BHT_N; i++) bht_m[i] = 1;

    repeat (2) @(negedge clk);
    check1("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check1("rst_valid", iq_out_valid, 1'b0);
    check("rst_inst", iq_out_inst, 32'h0);
    check("rst_pc", iq_out_pc, 32'h0);
    check1("rst_pred", iq_out_pred_taken, 1'b0);

    rst_n = 1'b1;
    tick();
    check1("req_rise", mem_req, 1'b1);
    check("first_addr", mem_addr, 32'h0);

    for (int i = 0; i < DEPTH; i++) begin
      wait_req("fill_req");
      check("fill_addr", mem_addr, 32'(i * 4));
      mem_ack = 1'b1; mem_inst = 32'h00000013;
      tick();
      mem_ack = 1'b0;
    end
    check1("full_req_low", mem_req, 1'b0);
    check1("full_valid", iq_out_valid, 1'b1);
    check("full_head_pc", iq_out_pc, 32'h0);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("pop_head_pc", iq_out_pc, 32'h4);
    wait_req("refill_req");
    check("refill_addr", mem_addr, 32'h20);

    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

`ifdef BHT_EN
    br_update = 1'b1; br_update_pc = 32'h40; br_update_taken = 1'b1;
    tick();
    tick();
    br_update = 1'b0;
    bht_train(32'h40, 1'b1);
    bht_train(32'h40, 1'b1);
    apply_vec('{32'h40, 32'hfe000ee3, 32'h3c, 1'b1});
`endif

    sync(32'h500);
    wait_req("fl_req");
    for (int i = 0; i < 3; i++) begin
      check("fl_fill_addr", mem_addr, 32'h500 + 32'(i * 4));
      mem_ack = 1'b1; mem_inst = 32'h00000013;
      tick();
      mem_ack = 1'b0;
    end
    check1("fl_pre_valid", iq_out_valid, 1'b1);
    flush = 1'b1; flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    check1("fl_valid_low", iq_out_valid, 1'b0);
    check1("fl_req_held", mem_req, 1'b1);
    check("fl_addr_held", mem_addr, 32'h50c);
    tick();
    tick();
    mem_ack = 1'b1; mem_inst = 32'h0080006f;
    tick();
    mem_ack = 1'b0;
    check1("fl_drop_valid", iq_out_valid, 1'b0);
    check1("fl_drop_req", mem_req, 1'b1);
    check("fl_redirect_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_inst = 32'h00000013;
    tick();
    mem_ack = 1'b0;
    check1("fl_new_valid", iq_out_valid, 1'b1);
    check("fl_new_pc", iq_out_pc, 32'h100);
    check("fl_new_next", mem_addr, 32'h104);

    sync(32'h1000);
    pops = 0;
    traffic(30, 100, 0, 0, 0, 1'b0);
    traffic(60, 100, 100, 0, 0, 1'b0);
    check1("wrap_pops", pops >= 20, 1'b1);

    sync(32'h80);
    traffic(3000, 50, 50, 3, 10, 1'b1);

    sync(32'h40);
    wait_req("rst_mid_req");
    rst_n = 1'b0;
    #1;
    check1("rst_mid_req_low", mem_req, 1'b0);
    check1("rst_mid_valid", iq_out_valid, 1'b0);
    check("rst_mid_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_inst = 32'h00000013;
    tick();
    mem_ack = 1'b0;
    check1("rst_rel_req", mem_req, 1'b1);
    check("rst_rel_addr", mem_addr, 32'h0);
    check1("rst_rel_ack_ignored", iq_out_valid, 1'b0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check1("rst_rel_push", iq_out_valid, 1'b1);
    check("rst_rel_pc", iq_out_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit with an instruction queue, directly upstream of the decode/issue stage. It requests 32-bit words from the memory controller one at a time and predicts the next PC from each returned word (JAL, B-type, optional branch history table). It buffers {inst, pc, predicted-taken} in a FIFO whose head feeds the decoder's `inst` input, and redirects on a flush from the reorder buffer.

## Interface
- `IQ_DEPTH`, 8: queue entries; power of two, ≥2.
- `BHT_SIZE`, 256: 2-bit counters (only with `BHT_EN`); power of two.
- `RESET_PC`, 32'h0: first fetch address.

Ports:
- `clk` in 1: single clock; everything is posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_req` out 1: fetch request.
- `mem_addr` out 32: fetch address, stable while `mem_req`=1.
- `mem_ack` in 1: one-cycle pulse; `mem_inst` is valid this cycle.
- `mem_inst` in 32: fetched word.
- `iq_out_valid` out 1: queue non-empty.
- `iq_out_inst` out 32: head instruction, to the decoder.
- `iq_out_pc` out 32: head PC.
- `iq_out_pred_taken` out 1: head was predicted taken; JAL is always 1.
- `issue_ready` in 1: downstream accepts the head this cycle.
- `flush` in 1: redirect (mispredict, JALR).
- `flush_pc` in 32: redirect target.
- `br_update` in 1: resolved B-type branch; ignored without `BHT_EN`.
- `br_update_pc` in 32: PC of the resolved branch.
- `br_update_taken` in 1: resolved outcome.

## Operation
- States:
  - IDLE: no request outstanding.
  - BUSY: request outstanding.
  - DISCARD: request outstanding, but its data is stale.
- IDLE, `count<IQ_DEPTH`, no flush: `mem_req`<=1, `mem_addr`<=pc, go to BUSY.
- BUSY, `mem_ack`, no flush:
  - Push {`mem_inst`, pc, pred}.
  - pc<=next_pc.
  - If post-push count < `IQ_DEPTH`: `mem_addr`<=next_pc, stay in BUSY with `mem_req`=1 (back-to-back).
  - Otherwise: `mem_req`<=0, go to IDLE.
- next_pc, all arithmetic 32-bit wrapping:
  - opcode 7'h6f (JAL): pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - opcode 7'h63 with predicted taken: pc + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - Otherwise (including JALR): pc+4.
- Queue:
  - Circular, `count` 0..`IQ_DEPTH`.
  - Pop when `iq_out_valid && issue_ready`.
  - Push and pop in the same cycle leaves count unchanged, including at full.
  - A push never overflows: a request is issued only with space free, and count cannot rise while BUSY.
- Flush has top priority:
  - Queue emptied (count=0, pointers=0); pc<=`flush_pc`.
  - IDLE → IDLE.
  - BUSY without `mem_ack` → DISCARD; `mem_req` stays 1, old address held.
  - BUSY or DISCARD with `mem_ack` → data dropped; `mem_addr`<=`flush_pc`, BUSY.
  - DISCARD without ack → stay in DISCARD; pc takes the newest `flush_pc`.
- DISCARD, `mem_ack`, no flush: data dropped, `mem_addr`<=pc, go to BUSY.
- A pop in a flush cycle is still accepted downstream; queue contents are lost.

## Timing
- Reset values:
  - state IDLE, pc=`RESET_PC`.
  - `mem_req`=0, `mem_addr`=0.
  - count=0, `iq_out_valid`=0, `iq_out_inst`/`iq_out_pc`=0, `iq_out_pred_taken`=0.
  - BHT counters 2'b01.
- `mem_req` rises one cycle after reset deassertion.
- Entry pushed at the ack edge; `iq_out_valid`=1 the following cycle.
- Queue-head outputs are driven from registered storage; no combinational path from `mem_inst` to `iq_out_*`.
- `iq_out_valid`=0 the cycle after a flush edge.
- Reset mid-request: all state cleared immediately; a later `mem_ack` is ignored in IDLE.
- Steady state: one instruction per `mem_ack`; no bubble between ack and the next request.

## Configuration
- `BHT_EN` defined:
  - `BHT_SIZE` 2-bit saturating counters indexed by pc[log2(`BHT_SIZE`)+1:2].
  - B-type predicted taken iff counter[1]=1.
  - On `br_update`: counter +1 (saturating at 3) if taken, −1 (saturating at 0) otherwise.
  - A lookup and an update to the same index in the same cycle: the lookup sees the old value.
- `BHT_EN` undefined: no table; B-type always predicted not-taken; `br_update*` unused.

## Test plan
- Reset, memory acks 1 cycle after each request with 32'h00000013 → `mem_addr` 0,4,8,…; after 8 acks with `issue_ready`=0 the queue is full and `mem_req`=0. Then pop 1 → request at 32'h20.
- JAL 32'h0080006f at pc 32'h10 → next `mem_addr`=32'h18, `iq_out_pred_taken`=1. JAL 32'hff9ff06f at pc 32'h10 → 32'h08.
- BEQ 32'hfe000ee3 at pc 32'h40, without `BHT_EN` → next 32'h44. With `BHT_EN` after two `br_update_taken`=1 at pc 32'h40 → next 32'h3c.
- `flush`=1, `flush_pc`=32'h100 while BUSY, ack 3 cycles later → acked data not queued; next `mem_addr`=32'h100; `iq_out_valid`=0 one cycle after flush.
- Full queue with push and pop in the same cycle → count stays 8; FIFO order preserved across pointer wrap for 20 instructions.
- `rst_n` asserted mid-request → `mem_req`=0 immediately; after release, first `mem_addr`=`RESET_PC`.
